tetris_drop_ctrl: RTL and testbench

TETRIS_DROP_CTRL -- requirements
Module: tetris_drop_ctrl

---
 rtl/tetris_drop_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tetris_drop_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_drop_ctrl.sv
// Falling-block playfield controller: 12x12 grid, one piece falls per gravity tick,
// locks onto the stack, and full rows are collapsed one row per cycle.
module tetris_drop_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         tick,
    input  logic [143:0] spawn_mask,
    output logic [143:0] backGround,
    output logic [143:0] currentSqs,
    output logic [7:0]   score,
    output logic         spawn_ack,
    output logic         busy,
    output logic         game_over
);

    localparam int COLS = 12;
    localparam int ROWS = 12;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SPAWN    = 3'd1,
        S_FALL     = 3'd2,
        S_LOCK     = 3'd3,
        S_CLEAR    = 3'd4,
        S_GAMEOVER = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [143:0]   bg_q, bg_d;
    logic [143:0]   cur_q, cur_d;
    logic [7:0]     score_q, score_d;
    logic [3:0]     row_q, row_d;
    logic           ack_q, ack_d;
    logic           busy_q, busy_d;
    logic           go_q, go_d;

    logic           bottom_s;
    logic           row_full_s;
    logic [143:0]   cleared_s;

    function automatic logic row_is_full(input logic [143:0] grid, input logic [3:0] r);
        return &grid[r*COLS +: COLS];
    endfunction

    // Piece rests when it touches the floor or sits directly above a locked cell.
    always_comb begin
        bottom_s   = (|cur_q[143:132]) | (|(cur_q[131:0] & bg_q[143:12]));
        row_full_s = row_is_full(bg_q, row_q);
    end

    // Board with the pointed-at row removed and everything above it moved down one row.
    always_comb begin
        cleared_s = bg_q;
        for (int rr = 0; rr < ROWS; rr++) begin
            if (rr == 0) begin
                cleared_s[0 +: COLS] = {COLS{1'b0}};
            end else if (4'(rr) <= row_q) begin
                cleared_s[rr*COLS +: COLS] = bg_q[(rr-1)*COLS +: COLS];
            end else begin
                cleared_s[rr*COLS +: COLS] = bg_q[rr*COLS +: COLS];
            end
        end
    end

    // Next-state and datapath updates for the game sequencer.
    always_comb begin
        state_d = state_q;
        bg_d    = bg_q;
        cur_d   = cur_q;
        score_d = score_q;
        row_d   = row_q;
        ack_d   = 1'b0;
        case (state_q)
            S_IDLE, S_GAMEOVER: begin
                if (start) begin
                    bg_d    = 144'd0;
                    cur_d   = 144'd0;
                    score_d = 8'd0;
                    row_d   = 4'd11;
                    state_d = S_SPAWN;
                end else begin
                    state_d = state_q;
                end
            end
            S_SPAWN: begin
                if (|(spawn_mask & bg_q)) begin
                    state_d = S_GAMEOVER;
                end else begin
                    cur_d   = spawn_mask;
                    ack_d   = 1'b1;
                    state_d = S_FALL;
                end
            end
            S_FALL: begin
                if (tick && bottom_s) begin
                    state_d = S_LOCK;
                end else if (tick) begin
                    cur_d = {cur_q[131:0], 12'd0};
                end else begin
                    cur_d = cur_q;
                end
            end
            S_LOCK: begin
                bg_d    = bg_q | cur_q;
                cur_d   = 144'd0;
                row_d   = 4'd11;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                // A full row is collapsed and the same row index is examined again.
                if (row_full_s) begin
                    bg_d = cleared_s;
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end else begin
                        score_d = score_q;
                    end
                end else if (row_q == 4'd0) begin
                    state_d = S_SPAWN;
                end else begin
                    row_d = row_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_LOCK) || (state_d == S_CLEAR) || (state_d == S_SPAWN);
        go_d   = (state_d == S_GAMEOVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bg_q    <= 144'd0;
            cur_q   <= 144'd0;
            score_q <= 8'd0;
            row_q   <= 4'd11;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bg_q    <= bg_d;
            cur_q   <= cur_d;
            score_q <= score_d;
            row_q   <= row_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            go_q    <= go_d;
        end
    end

    assign backGround = bg_q;
    assign currentSqs = cur_q;
    assign score      = score_q;
    assign spawn_ack  = ack_q;
    assign busy       = busy_q;
    assign game_over  = go_q;

endmodule

// File: tb/tb_tetris_drop_ctrl.sv
// Directed-vector bench for tetris_drop_ctrl: reset, drops, stacking, line clears,
// game over and ignored inputs, each with hand-computed expectations.
module tb_tetris_drop_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         tick;
    logic [143:0] spawn_mask;
    logic [143:0] backGround;
    logic [143:0] currentSqs;
    logic [7:0]   score;
    logic         spawn_ack;
    logic         busy;
    logic         game_over;

    int n_vec = 0;
    int n_err = 0;

    tetris_drop_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tick       (tick),
        .spawn_mask (spawn_mask),
        .backGround (backGround),
        .currentSqs (currentSqs),
        .score      (score),
        .spawn_ack  (spawn_ack),
        .busy       (busy),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output int n);
        bit found;
        found = 1'b0;
        n = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            if (!found) begin
                step();
                if (spawn_ack === 1'b1) begin
                    found = 1'b1;
                    n = i;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; tick = 1'b1; spawn_mask = 144'd1 << 5;
        step(); step();
        reset = 1'b0; start = 1'b0; tick = 1'b0;
        n_vec++;
        if ({backGround, currentSqs} !== 288'd0) begin
            n_err++; $display("FAIL reset_board: got bg=%h cur=%h required 0", backGround, currentSqs);
        end
        n_vec++;
        if ({score, spawn_ack, busy, game_over} !== 11'd0) begin
            n_err++; $display("FAIL reset_flags: got score=%0d ack=%b busy=%b go=%b required 0", score, spawn_ack, busy, game_over);
        end
        step();
        n_vec++;
        if ({busy, spawn_ack} !== 2'b00) begin
            n_err++; $display("FAIL reset_idle: got busy=%b ack=%b required 0 0", busy, spawn_ack);
        end
    endtask

    task automatic test_single_drop();
        int n;
        spawn_mask = 144'd1 << 5;
        start = 1'b1; step(); start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL spawn_busy: got %b required 1", busy);
        end
        step();
        n_vec++;
        if (spawn_ack !== 1'b1 || currentSqs !== (144'd1 << 5)) begin
            n_err++; $display("FAIL spawn_load: got ack=%b cur=%h required 1 %h", spawn_ack, currentSqs, 144'd1 << 5);
        end
        tick = 1'b1;
        repeat (11) step();
        n_vec++;
        if (currentSqs !== (144'd1 << 137) || spawn_ack !== 1'b0) begin
            n_err++; $display("FAIL drop_11: got cur=%h ack=%b required %h 0", currentSqs, spawn_ack, 144'd1 << 137);
        end
        step();
        n_vec++;
        if (currentSqs !== (144'd1 << 137) || busy !== 1'b1) begin
            n_err++; $display("FAIL lock_tick: got cur=%h busy=%b required %h 1", currentSqs, busy, 144'd1 << 137);
        end
        step();
        n_vec++;
        if (backGround !== (144'd1 << 137) || currentSqs !== 144'd0) begin
            n_err++; $display("FAIL lock_merge: got bg=%h cur=%h required %h 0", backGround, currentSqs, 144'd1 << 137);
        end
        wait_ack(30, n);
        tick = 1'b0;
        n_vec++;
        if (n !== 13) begin
            n_err++; $display("FAIL clear_len_single: got %0d cycles required 13", n);
        end
        n_vec++;
        if (currentSqs !== (144'd1 << 5)) begin
            n_err++; $display("FAIL tick_ignored: got cur=%h required %h", currentSqs, 144'd1 << 5);
        end
    endtask

    task automatic test_stacking();
        tick = 1'b1;
        repeat (10) step();
        n_vec++;
        if (currentSqs !== (144'd1 << 125)) begin
            n_err++; $display("FAIL stack_fall: got %h required %h", currentSqs, 144'd1 << 125);
        end
        step();
        tick = 1'b0;
        n_vec++;
        if (currentSqs !== (144'd1 << 125) || busy !== 1'b1) begin
            n_err++; $display("FAIL stack_lock_tick: got cur=%h busy=%b required %h 1", currentSqs, busy, 144'd1 << 125);
        end
        step();
        n_vec++;
        if (backGround !== ((144'd1 << 137) | (144'd1 << 125)) || currentSqs !== 144'd0) begin
            n_err++; $display("FAIL stack_bg: got bg=%h cur=%h required %h 0", backGround, currentSqs, (144'd1 << 137) | (144'd1 << 125));
        end
    endtask

    task automatic test_reset_mid_clear();
        step(); step(); step();
        reset = 1'b1; tick = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; tick = 1'b0; start = 1'b0;
        n_vec++;
        if ({backGround, currentSqs, score, spawn_ack, busy, game_over} !== 299'd0) begin
            n_err++; $display("FAIL reset_mid_clear: got bg=%h cur=%h score=%0d busy=%b required all 0", backGround, currentSqs, score, busy);
        end
    endtask

    task automatic test_line_clear();
        int n;
        spawn_mask = 144'hFFF;
        start = 1'b1; step(); start = 1'b0;
        step();
        tick = 1'b1;
        repeat (11) step();
        n_vec++;
        if (currentSqs !== (144'hFFF << 132)) begin
            n_err++; $display("FAIL row_fall: got %h required %h", currentSqs, 144'hFFF << 132);
        end
        step();
        tick = 1'b0;
        step();
        spawn_mask = (144'hFFF << 12) | (144'd1 << 5);
        wait_ack(30, n);
        n_vec++;
        if (n !== 14 || backGround !== 144'd0 || score !== 8'd1) begin
            n_err++; $display("FAIL clear_bottom: got len=%0d bg=%h score=%0d required 14 0 1", n, backGround, score);
        end
        tick = 1'b1;
        repeat (11) step();
        tick = 1'b0;
        step();
        n_vec++;
        if (backGround !== ((144'hFFF << 132) | (144'd1 << 125))) begin
            n_err++; $display("FAIL shape_lock: got %h required %h", backGround, (144'hFFF << 132) | (144'd1 << 125));
        end
        spawn_mask = 144'd1 << 5;
        wait_ack(30, n);
        n_vec++;
        if (n !== 14 || backGround !== (144'd1 << 137) || score !== 8'd2) begin
            n_err++; $display("FAIL clear_shift: got len=%0d bg=%h score=%0d required 14 %h 2", n, backGround, score, 144'd1 << 137);
        end
    endtask

    task automatic test_game_over();
        int n;
        int acks;
        logic [143:0] col5;
        col5 = 144'd0;
        for (int r = 0; r < 12; r++) col5[5 + 12*r] = 1'b1;
        reset = 1'b1; step(); step(); reset = 1'b0;
        spawn_mask = 144'd1 << 5;
        start = 1'b1; step(); start = 1'b0;
        step();
        for (int k = 0; k < 12; k++) begin
            tick = 1'b1;
            repeat (12 - k) step();
            tick = 1'b0;
            step();
            if (k < 11) begin
                wait_ack(30, n);
                n_vec++;
                if (n !== 13) begin
                    n_err++; $display("FAIL stack_%0d: got %0d cycles required 13", k, n);
                end
            end
        end
        acks = 0;
        for (int i = 0; i < 13; i++) begin
            step();
            if (spawn_ack === 1'b1) acks++;
        end
        n_vec++;
        if (acks !== 0 || game_over !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL game_over: got acks=%0d go=%b busy=%b required 0 1 0", acks, game_over, busy);
        end
        n_vec++;
        if (backGround !== col5) begin
            n_err++; $display("FAIL go_board: got %h required %h", backGround, col5);
        end
        tick = 1'b1;
        repeat (3) step();
        tick = 1'b0;
        n_vec++;
        if (backGround !== col5 || game_over !== 1'b1 || spawn_ack !== 1'b0) begin
            n_err++; $display("FAIL go_hold: got bg=%h go=%b ack=%b required %h 1 0", backGround, game_over, spawn_ack, col5);
        end
        start = 1'b1; step(); start = 1'b0;
        n_vec++;
        if (backGround !== 144'd0 || game_over !== 1'b0 || score !== 8'd0) begin
            n_err++; $display("FAIL restart_clear: got bg=%h go=%b score=%0d required 0 0 0", backGround, game_over, score);
        end
        step();
        n_vec++;
        if (spawn_ack !== 1'b1 || currentSqs !== (144'd1 << 5)) begin
            n_err++; $display("FAIL restart_spawn: got ack=%b cur=%h required 1 %h", spawn_ack, currentSqs, 144'd1 << 5);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tick = 1'b0; spawn_mask = 144'd0;
        test_reset();
        test_single_drop();
        test_stacking();
        test_reset_mid_clear();
        test_line_clear();
        test_game_over();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
